// File: rtl/key_expand_sched_if.sv
// Handshake bundle for key_expand_sched: the key load goes in, the round-key stream comes out.
// The rk_replay signal exists only when KEYSCHED_REPLAY_EN is defined.
interface key_expand_sched_if;
  logic [127:0] SecretKey;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;
`ifdef KEYSCHED_REPLAY_EN
  logic         rk_replay;

  modport master (output SecretKey, key_valid, rk_ready, rk_replay,
                  input  key_ready, busy, rk_data, rk_round, rk_last, rk_valid);
  modport slave  (input  SecretKey, key_valid, rk_ready, rk_replay,
                  output key_ready, busy, rk_data, rk_round, rk_last, rk_valid);
`else
  modport master (output SecretKey, key_valid, rk_ready,
                  input  key_ready, busy, rk_data, rk_round, rk_last, rk_valid);
  modport slave  (input  SecretKey, key_valid, rk_ready,
                  output key_ready, busy, rk_data, rk_round, rk_last, rk_valid);
`endif
endinterface

// File: rtl/key_expand_sched.sv
// AES-128 key expansion (one round key per cycle), then a stream of round keys 10..0 in decrypt order.
// With KEYSCHED_REPLAY_EN defined, the keys are retained in HOLD and rk_replay restreams them.
module key_expand_sched (
  input  logic             clk,
  input  logic             rst_n,
  key_expand_sched_if.slave bus
);

`ifdef KEYSCHED_REPLAY_EN
  typedef enum logic [1:0] {IDLE, EXPAND, STREAM, HOLD} state_t;
  localparam state_t DONE_STATE = HOLD;
`else
  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;
  localparam state_t DONE_STATE = IDLE;
`endif

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  state_t       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] rk_q [0:10];
  logic         load_key;
  logic [7:0]   rcon;
  logic [127:0] prev_key, next_key;
  logic [31:0]  rot_word, sub_word, nw0, nw1, nw2, nw3;

  always_comb begin
    unique case (idx_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Round key idx_q is derived from round key idx_q-1, which was written on the previous edge.
  always_comb begin
    prev_key = rk_q[idx_q - 4'd1];
    rot_word = {prev_key[23:0], prev_key[31:24]};
    sub_word = {SBOX[rot_word[31:24]], SBOX[rot_word[23:16]],
                SBOX[rot_word[15:8]],  SBOX[rot_word[7:0]]};
    nw0      = prev_key[127:96] ^ sub_word ^ {rcon, 24'h000000};
    nw1      = prev_key[95:64]  ^ nw0;
    nw2      = prev_key[63:32]  ^ nw1;
    nw3      = prev_key[31:0]   ^ nw2;
    next_key = {nw0, nw1, nw2, nw3};
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    load_key      = 1'b0;
    bus.key_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.rk_valid  = 1'b0;
    bus.rk_last   = 1'b0;
    bus.rk_round  = '0;
    bus.rk_data   = '0;
    unique case (state_q)
      IDLE: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) begin
          load_key = 1'b1;
          state_d  = EXPAND;
          idx_d    = 4'd1;
        end
      end
      EXPAND: begin
        bus.busy = 1'b1;
        if (idx_q == 4'd10) state_d = STREAM;
        else                idx_d   = idx_q + 4'd1;
      end
      STREAM: begin
        bus.busy     = 1'b1;
        bus.rk_valid = 1'b1;
        bus.rk_round = idx_q;
        bus.rk_data  = rk_q[idx_q];
        bus.rk_last  = (idx_q == 4'd0);
        if (bus.rk_ready) begin
          if (idx_q == 4'd0) state_d = DONE_STATE;
          else               idx_d   = idx_q - 4'd1;
        end
      end
`ifdef KEYSCHED_REPLAY_EN
      HOLD: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) begin
          load_key = 1'b1;
          state_d  = EXPAND;
          idx_d    = 4'd1;
        end else if (bus.rk_replay) begin
          state_d = STREAM;
          idx_d   = 4'd10;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int unsigned i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load_key)                rk_q[0]     <= bus.SecretKey;
      else if (state_q == EXPAND)  rk_q[idx_q] <= next_key;
    end
  end

endmodule

// File: tb/tb_key_expand_sched.sv
// Directed bench for key_expand_sched: FIPS-197 and all-zero key streams, backpressure, ignored keys, abort.
// Define KEYSCHED_REPLAY_EN to also exercise HOLD/replay.
module tb_key_expand_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_expand_sched_if bus ();
  key_expand_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [127:0] key;
    logic [3:0]   round;
    logic [127:0] data;
  } vec_t;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h0;
  localparam logic [127:0] KEY_X = 128'hdeadbeef0123456789abcdeffedcba98;

  vec_t tbl [22];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfers key k (optionally with rk_replay raised at the same time), then counts the
  // ten expansion cycles; rk_valid must appear exactly on the tenth edge.
  task automatic load_and_wait(input logic [127:0] k, input bit poke, input bit with_replay);
    bus.SecretKey = k;
    bus.key_valid = 1'b1;
`ifdef KEYSCHED_REPLAY_EN
    bus.rk_replay = with_replay;
`else
    if (with_replay) $display("note: replay not built");
`endif
    chk("key_ready_before_load", bus.key_ready, 1'b1);
    tick();
    bus.key_valid = 1'b0;
`ifdef KEYSCHED_REPLAY_EN
    bus.rk_replay = 1'b0;
`endif
    chk("busy_after_load", bus.busy, 1'b1);
    chk("rk_valid_after_load", bus.rk_valid, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (poke && c == 3) begin
        bus.SecretKey = KEY_X;
        bus.key_valid = 1'b1;
        chk("key_ready_in_expand", bus.key_ready, 1'b0);
      end
      tick();
      bus.key_valid = 1'b0;
      chk($sformatf("rk_valid_latency_c%0d", c), bus.rk_valid, (c == 10));
    end
  endtask

  task automatic stream(input int base, input bit stall, input bit poke);
    for (int b = 0; b < 11; b++) begin
      vec_t e;
      e = tbl[base + b];
      if (stall && e.round == 4'd7) begin
        bus.rk_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          chk("stall_valid", bus.rk_valid, 1'b1);
          chk("stall_round", bus.rk_round, e.round);
          chk("stall_data", bus.rk_data, e.data);
          tick();
        end
        bus.rk_ready = 1'b1;
      end
      chk($sformatf("beat_valid_r%0d", e.round), bus.rk_valid, 1'b1);
      chk($sformatf("beat_round_r%0d", e.round), bus.rk_round, e.round);
      chk($sformatf("beat_data_r%0d", e.round), bus.rk_data, e.data);
      chk($sformatf("beat_last_r%0d", e.round), bus.rk_last, (e.round == 4'd0));
      if (poke && e.round == 4'd5) begin
        bus.SecretKey = KEY_X;
        bus.key_valid = 1'b1;
        chk("key_ready_in_stream", bus.key_ready, 1'b0);
      end
      tick();
      bus.key_valid = 1'b0;
    end
    chk("post_stream_valid", bus.rk_valid, 1'b0);
    chk("post_stream_busy", bus.busy, 1'b0);
    chk("post_stream_key_ready", bus.key_ready, 1'b1);
    chk("post_stream_data", bus.rk_data, 128'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, bus.key_ready, 1'b1);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_rk_valid"}, bus.rk_valid, 1'b0);
    chk({tag, "_rk_last"}, bus.rk_last, 1'b0);
    chk({tag, "_rk_data"}, bus.rk_data, 128'h0);
    chk({tag, "_rk_round"}, bus.rk_round, 4'd0);
  endtask

  initial begin
    tbl[0]  = '{KEY_A, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[1]  = '{KEY_A, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
    tbl[2]  = '{KEY_A, 4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    tbl[3]  = '{KEY_A, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    tbl[4]  = '{KEY_A, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    tbl[5]  = '{KEY_A, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    tbl[6]  = '{KEY_A, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    tbl[7]  = '{KEY_A, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    tbl[8]  = '{KEY_A, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    tbl[9]  = '{KEY_A, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[10] = '{KEY_A, 4'd0,  KEY_A};
    tbl[11] = '{KEY_B, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    tbl[12] = '{KEY_B, 4'd9,  128'hb1d4d8e28a7db9da1d7bb3de4c664941};
    tbl[13] = '{KEY_B, 4'd8,  128'h0ef903333ba9613897060a04511dfa9f};
    tbl[14] = '{KEY_B, 4'd7,  128'h217517873550620bacaf6b3cc61bf09b};
    tbl[15] = '{KEY_B, 4'd6,  128'hec614b851425758c99ff09376ab49ba7};
    tbl[16] = '{KEY_B, 4'd5,  128'h7f2e2b88f8443e098dda7cbbf34b9290};
    tbl[17] = '{KEY_B, 4'd4,  128'hee06da7b876a1581759e42b27e91ee2b};
    tbl[18] = '{KEY_B, 4'd3,  128'h90973450696ccffaf2f457330b0fac99};
    tbl[19] = '{KEY_B, 4'd2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    tbl[20] = '{KEY_B, 4'd1,  128'h62636363626363636263636362636363};
    tbl[21] = '{KEY_B, 4'd0,  KEY_B};

    rst_n         = 1'b0;
    bus.SecretKey = '0;
    bus.key_valid = 1'b0;
    bus.rk_ready  = 1'b1;
`ifdef KEYSCHED_REPLAY_EN
    bus.rk_replay = 1'b0;
`endif
    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // FIPS-197 key with a key poke in both EXPAND and STREAM and a 5-cycle stall at round 7
    load_and_wait(tbl[0].key, 1'b1, 1'b0);
    stream(0, 1'b1, 1'b1);

    load_and_wait(tbl[11].key, 1'b0, 1'b0);
    stream(11, 1'b0, 1'b0);

    // Abort an expansion with reset, then the next key must stream on its own
    bus.SecretKey = KEY_B;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort_async");
    tick();
    tick();
    chk_reset_outputs("abort_held");
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("no_stale_beat", bus.rk_valid, 1'b0);
    end
    load_and_wait(tbl[0].key, 1'b0, 1'b0);
    stream(0, 1'b0, 1'b0);

`ifdef KEYSCHED_REPLAY_EN
    tick();
    chk("hold_valid", bus.rk_valid, 1'b0);
    bus.rk_replay = 1'b1;
    tick();
    bus.rk_replay = 1'b0;
    stream(0, 1'b0, 1'b0);
    // Key transfer wins over a simultaneous replay request
    load_and_wait(tbl[11].key, 1'b0, 1'b1);
    stream(11, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_expand_sched.md
KEY_EXPAND_SCHED -- requirements
Module: key_expand_sched

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port SecretKey, input, 128 bits: the AES-128 cipher key, with bits [127:120] holding byte 0.
REQ-004 The block SHALL have the port key_valid, input, 1 bit: SecretKey is valid this cycle.
REQ-005 The block SHALL have the port key_ready, output, 1 bit: the block will accept a key this cycle.
REQ-006 The block SHALL have the port busy, output, 1 bit: high while expanding or streaming.
REQ-007 The block SHALL have the port rk_data, output, 128 bits: the round key currently offered.
REQ-008 The block SHALL have the port rk_round, output, 4 bits: the round index of rk_data, in the range 0..10.
REQ-009 The block SHALL have the port rk_last, output, 1 bit: high with rk_valid when rk_round==0.
REQ-010 The block SHALL have the port rk_valid, output, 1 bit: rk_data is valid this cycle.
REQ-011 The block SHALL have the port rk_ready, input, 1 bit: the downstream decrypt datapath accepts rk_data this cycle.

Function
REQ-012 The block SHALL have the states IDLE, EXPAND and STREAM, plus HOLD when KEYSCHED_REPLAY_EN is defined.
REQ-013 key_ready SHALL be 1 only in IDLE (and in HOLD); a key transfer occurs on a rising edge where key_valid&&key_ready.
REQ-014 On a key transfer, SecretKey SHALL be stored as round key 0, the round counter SHALL be set to 1, and the state SHALL become EXPAND.
REQ-015 In EXPAND, the block SHALL produce one round key per cycle using the FIPS-197 schedule: w[i] = w[i-4] ^ SubWord(RotWord(w[i-1])) ^ Rcon for the first word, and w[i] = w[i-4] ^ w[i-1] for the remaining three words.
REQ-016 Rcon SHALL follow the sequence 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10, applied to the top byte of the word.
REQ-017 SubWord SHALL use four internal forward S-box lookups (combinational); no other S-box resources are shared.
REQ-018 Round keys 0..10 SHALL be held in an internal 1408-bit register file.
REQ-019 On the edge that stores round key 10, the state SHALL become STREAM with the index at 10.
REQ-020 rk_valid SHALL therefore rise exactly 10 cycles after the key-transfer edge.
REQ-021 In STREAM, rk_valid SHALL be 1 and rk_data/rk_round SHALL equal key[index]; the order is decrypt order, 10 down to 0.
REQ-022 A beat SHALL transfer when rk_valid&&rk_ready; the index then decrements.
REQ-023 While rk_ready is 0, rk_data, rk_round and rk_last SHALL be held stable.
REQ-024 When the beat with rk_round 0 transfers, the state SHALL become IDLE (or HOLD).
REQ-025 key_valid while the state is EXPAND or STREAM SHALL be ignored, with key_ready=0.
REQ-026 busy SHALL be 1 in EXPAND and STREAM, and 0 otherwise.
REQ-027 rk_valid SHALL be 0 outside STREAM, and rk_data SHALL read 0 outside STREAM.

Reset
REQ-028 While rst_n is 0: state=IDLE, index=0, key_ready=1, busy=0, rk_valid=0, rk_last=0, rk_data=0, rk_round=0, and the register file is cleared.
REQ-029 Reset asserted mid-EXPAND or mid-STREAM SHALL abort immediately; after release, no stale beat is emitted and the next key starts a fresh expansion.

Configuration
REQ-030 The preprocessor macro KEYSCHED_REPLAY_EN SHALL control the replay feature.
REQ-031 With KEYSCHED_REPLAY_EN defined: an input port rk_replay (1 bit) SHALL be added; after the last beat the state SHALL become HOLD with the keys retained.
REQ-032 With KEYSCHED_REPLAY_EN defined: rk_replay=1 in HOLD SHALL enter STREAM at index 10 on the next edge, without re-expansion.
REQ-033 With KEYSCHED_REPLAY_EN defined: a key transfer in HOLD SHALL take priority over a simultaneous rk_replay.
REQ-034 Without KEYSCHED_REPLAY_EN: no rk_replay port and no HOLD state SHALL exist; the block returns to IDLE after the last beat and a new key is needed for each stream.

Verification
REQ-035 The bench SHALL apply key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> the first beat is rk_round=10, rk_data=d014f9a8c9ee2589e13f0cc8b6630ca6, 10 cycles after acceptance; beat round 1 is a0fafe1788542cb123a339392a6c7605; beat round 0 equals the key with rk_last=1.
REQ-036 The bench SHALL apply an all-zero key -> round-10 beat b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-037 The bench SHALL hold rk_ready=0 for 5 cycles at round 7 -> rk_data/rk_round stable for all 5 cycles; the round-7 beat transfers once; the next beat is round 6.
REQ-038 The bench SHALL pulse key_valid with a different key during EXPAND and during STREAM -> key_ready=0; the output sequence is unchanged.
REQ-039 The bench SHALL assert rst_n=0 at expansion cycle 4, then load a new key -> all outputs are 0 during reset; the stream is correct for the new key only.
REQ-040 With KEYSCHED_REPLAY_EN defined, the bench SHALL pulse rk_replay in HOLD -> rk_valid on the next cycle with round 10 and an identical 11-beat sequence.
